// File: rtl/mem_stage_pkg.sv
// Shared memory-op codes, FSM encoding, byte-lane masks and the pipeline register layout for mem_stage.
package mem_stage_pkg;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    localparam logic [3:0] SEL_BYTE_HI = 4'b1000;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
    } pipe_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0; bytes are always aligned.
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        return (((op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH)) && a[0]) ||
               (((op == MEM_OP_LW) || (op == MEM_OP_SW)) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Big-endian lane handling: load byte/half extraction with sign/zero extension, store enables and replication.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [3:0]  sel,
    output logic [31:0] wdata
);
    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    always_comb begin
        lbyte = 8'h00;
        case (addr_lo)
            2'd0:    lbyte = rdata[31:24];
            2'd1:    lbyte = rdata[23:16];
            2'd2:    lbyte = rdata[15:8];
            default: lbyte = rdata[7:0];
        endcase
        lhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        ldata = rdata;
        case (op)
            MEM_OP_LB:  ldata = {{24{lbyte[7]}}, lbyte};
            MEM_OP_LBU: ldata = {24'h000000, lbyte};
            MEM_OP_LH:  ldata = {{16{lhalf[15]}}, lhalf};
            MEM_OP_LHU: ldata = {16'h0000, lhalf};
            default:    ldata = rdata;
        endcase

        sel   = 4'b0000;
        wdata = 32'h0;
        case (op)
            MEM_OP_SB: begin
                sel   = SEL_BYTE_HI >> addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_OP_SH: begin
                sel   = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
                wdata = {2{sdata[15:0]}};
            end
            MEM_OP_SW: begin
                sel   = SEL_WORD;
                wdata = sdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access stage; stalls the pipe while a bus access is outstanding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_o_wreg,
    input  logic [4:0]  ex_o_waddr,
    input  logic [31:0] ex_o_wdata,
    input  logic        ex_o_we_hilo,
    input  logic [31:0] ex_o_wdata_hi,
    input  logic [31:0] ex_o_wdata_lo,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_sdata,
    output logic        stall_o,
    output logic        mem_o_wreg,
    output logic [4:0]  mem_o_waddr,
    output logic [31:0] mem_o_wdata,
    output logic        mem_o_we_hilo,
    output logic [31:0] mem_o_wdata_hi,
    output logic [31:0] mem_o_wdata_lo,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);
    localparam int CW = $clog2(TIMEOUT);

    pipe_t          r;
    state_t         state;
    logic [CW-1:0]  cnt;

    logic        in_req, ack_cycle, timeout_hit, r_load, r_store, err, ex_starts_req;
    logic [31:0] ldata, al_wdata;
    logic [3:0]  al_sel;

    mem_stage_align u_align (
        .op      (r.op),
        .addr_lo (r.addr[1:0]),
        .rdata   (dbus_rdata),
        .sdata   (r.sdata),
        .ldata   (ldata),
        .sel     (al_sel),
        .wdata   (al_wdata)
    );

    always_comb begin
        in_req        = (state == ST_REQ);
        ack_cycle     = in_req && dbus_ack;
        timeout_hit   = in_req && !dbus_ack && (cnt == CW'(TIMEOUT - 1));
        stall_o       = in_req && !dbus_ack && !timeout_hit;
        r_load        = is_load(r.op);
        r_store       = is_store(r.op);
        addr_err      = r.valid && (r_load || r_store) && misaligned(r.op, r.addr[1:0]);
        bus_err       = timeout_hit;
        err           = addr_err || bus_err;
        ex_starts_req = ex_valid && !flush && (is_load(ex_mem_op) || is_store(ex_mem_op)) &&
                        !misaligned(ex_mem_op, ex_mem_addr[1:0]);

        // Loads only retire in their ack cycle; a stalled stage hands a bubble to writeback.
        mem_o_wreg     = r.valid && r.wreg && !r_store && (!r_load || ack_cycle) && !err && !stall_o;
        mem_o_we_hilo  = r.valid && r.we_hilo && (!r_load || ack_cycle) && !err && !stall_o;
        mem_o_waddr    = r.waddr;
        mem_o_wdata    = (r_load && ack_cycle) ? ldata : r.wdata;
        mem_o_wdata_hi = r.hi;
        mem_o_wdata_lo = r.lo;

        dbus_req   = in_req;
        dbus_we    = in_req && r_store;
        dbus_addr  = in_req ? {r.addr[31:2], 2'b00} : 32'h0;
        dbus_sel   = in_req ? (r_load ? SEL_WORD : al_sel) : 4'b0000;
        dbus_wdata = in_req ? al_wdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!stall_o || flush) begin
            r.valid   <= ex_valid && !flush;
            r.wreg    <= ex_o_wreg;
            r.waddr   <= ex_o_waddr;
            r.wdata   <= ex_o_wdata;
            r.we_hilo <= ex_o_we_hilo;
            r.hi      <= ex_o_wdata_hi;
            r.lo      <= ex_o_wdata_lo;
            r.op      <= ex_mem_op;
            r.addr    <= ex_mem_addr;
            r.sdata   <= ex_mem_sdata;
            state     <= ex_starts_req ? ST_REQ : ST_IDLE;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
